// File: rtl/ras_pkg.sv
// Shared return-address-stack definitions, used by both the RAS controller and
// the storage block.
package ras_pkg;

    localparam int          XLEN              = 32;
    localparam logic [31:0] RAS_INVALID_PC    = 32'hFFFF_FFFF;
    localparam int          RAS_DEPTH_DEFAULT = 8;

endpackage : ras_pkg

// File: rtl/ras_mem.sv
// Return-address storage array: one synchronous write port and one
// asynchronous read port. The array has no reset; entries only become visible
// after the stack logic has written them.
module ras_mem
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Write the selected entry on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : ras_mem

// File: rtl/return_addr_stack.sv
// Storage half of the return address stack: a DEPTH-entry LIFO of return
// addresses, with top pointer, occupancy count and overflow/underflow pulses.
// The build macro RAS_OVERFLOW_WRAP_EN makes a push into a full stack
// overwrite the oldest entry. Without it, such a push is dropped.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int DEPTH  = RAS_DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] pctoras,
    output logic [XLEN-1:0] pcfromras,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   tos, tos_nxt;
    logic [CW-1:0]   count_nxt;
    logic            overflow_nxt, underflow_nxt;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   top_idx;
    logic [XLEN-1:0] top_data;

    assign top_idx = tos - AW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    ras_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (pctoras),
        .raddr (top_idx),
        .rdata (top_data)
    );

    // The controller consumes the pre-update top during a pop. An empty
    // stack reads as the invalid-PC marker, never as stale array contents.
    assign pcfromras = empty ? RAS_INVALID_PC : top_data;

    // Next-state decode. Priority: flush first, then push/pop.
    // Push+pop together means the top entry is replaced.
    always_comb begin
        tos_nxt       = tos;
        count_nxt     = count;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        we            = 1'b0;
        waddr         = tos;
        if (!reset_n) begin
            tos_nxt   = '0;
            count_nxt = '0;
        end else if (flush) begin
            tos_nxt   = '0;
            count_nxt = '0;
        end else if (push && pop && !empty) begin
            we    = 1'b1;
            waddr = top_idx;
        end else if (push) begin
            if (!full) begin
                we        = 1'b1;
                tos_nxt   = tos + AW'(1);
                count_nxt = count + CW'(1);
            end else begin
                overflow_nxt = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                // When full, tos also addresses the oldest entry.
                // Overwriting that slot keeps the newest DEPTH returns.
                we      = 1'b1;
                tos_nxt = tos + AW'(1);
`endif
            end
        end else if (pop) begin
            if (!empty) begin
                tos_nxt   = top_idx;
                count_nxt = count - CW'(1);
            end else begin
                underflow_nxt = 1'b1;
            end
        end
    end

    // Pointer, occupancy and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tos       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

endmodule : return_addr_stack

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack. It checks a directed vector table and an
// overflow/pop-back sequence, then compares randomized traffic against a
// queue-based LIFO model.
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] INV = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset_n, flush, push, pop;
    logic [31:0]   pctoras;
    logic [31:0]   pcfromras;
    logic          empty, full, overflow, underflow;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    return_addr_stack #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .pctoras   (pctoras),
        .pcfromras (pcfromras),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        logic        rn, fl, pu, po;
        logic [31:0] d;
        logic [31:0] e_pc;
        int          e_cnt;
        logic        e_empty, e_full, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    // Reference LIFO state: the back of the queue is the top of the stack.
    logic [31:0] q[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic fl, input logic pu, input logic po,
                         input logic [31:0] d);
        reset_n = rn; flush = fl; push = pu; pop = po; pctoras = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input int e_cnt,
                             input logic e_empty, input logic e_full,
                             input logic e_ovf, input logic e_unf);
        chk({tag, ".pc"},    pcfromras,      e_pc);
        chk({tag, ".count"}, 32'(count),     32'(e_cnt));
        chk({tag, ".empty"}, 32'(empty),     32'(e_empty));
        chk({tag, ".full"},  32'(full),      32'(e_full));
        chk({tag, ".ovf"},   32'(overflow),  32'(e_ovf));
        chk({tag, ".unf"},   32'(underflow), 32'(e_unf));
    endtask

    // Apply one cycle to the model using the stack rules directly.
    task automatic model_step(input logic rn, input logic fl, input logic pu, input logic po,
                              input logic [31:0] d);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (!rn || fl) begin
            q.delete();
        end else if (pu && po) begin
            if (q.size() == 0) q.push_back(d);
            else q[q.size()-1] = d;
        end else if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else begin
                m_ovf = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end else if (po) begin
            if (q.size() > 0) void'(q.pop_back());
            else m_unf = 1'b1;
        end
    endtask

    task automatic add(input logic rn, input logic fl, input logic pu, input logic po,
                       input logic [31:0] d, input logic [31:0] pc, input int c,
                       input logic e, input logic f, input logic o, input logic u);
        vec_t v;
        v.rn = rn; v.fl = fl; v.pu = pu; v.po = po; v.d = d;
        v.e_pc = pc; v.e_cnt = c; v.e_empty = e; v.e_full = f; v.e_ovf = o; v.e_unf = u;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          phase_bias;

        reset_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; pctoras = '0;

        //   rn fl pu po data           pc            cnt e  f  o  u
        add(0, 0, 0, 0, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 32'h104,       32'h104,      1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h208,       32'h208,      2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h30C,       32'h30C,      3, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         32'h208,      2, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         32'h104,      1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         INV,          0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(1, 0, 1, 1, 32'h400,       32'h400,      1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 32'h500,       32'h500,      1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h600,       32'h600,      2, 0, 0, 0, 0);
        add(1, 0, 1, 1, 32'h700,       32'h700,      2, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         32'h500,      1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h11,        32'h11,       2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h22,        32'h22,       3, 0, 0, 0, 0);
        add(1, 1, 1, 0, 32'h33,        INV,          0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 32'h44,        32'h44,       1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h55,        32'h55,       2, 0, 0, 0, 0);
        add(0, 0, 1, 0, 32'h66,        INV,          0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0,         INV,          0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h77,        32'h77,       2, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0,         32'hFFFF_FFFF, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].fl, vecs[i].pu, vecs[i].po, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                      vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill to DEPTH, then push one more while full and drain.
        drive(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 1, 0, 32'h100 + 32'(4 * i));
        end
        check_all("fill8", 32'h11C, DEPTH, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 32'h120);
`ifdef RAS_OVERFLOW_WRAP_EN
        check_all("push9", 32'h120, DEPTH, 0, 1, 1, 0);
`else
        check_all("push9", 32'h11C, DEPTH, 0, 1, 1, 0);
`endif
        drive(1, 0, 0, 0, 32'h0);
        chk("ovf_one_cycle", 32'(overflow), 32'h0);
        // Replacing the top of a full stack does not overflow in either build.
        drive(1, 0, 1, 1, 32'hABC);
        check_all("full_replace", 32'hABC, DEPTH, 0, 1, 0, 0);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            drive(1, 0, 0, 1, 32'h0);
`ifdef RAS_OVERFLOW_WRAP_EN
            exp_pc = (i == 0) ? INV : 32'h104 + 32'(4 * (i - 1));
`else
            exp_pc = (i == 0) ? INV : 32'h100 + 32'(4 * (i - 1));
`endif
            chk($sformatf("drain%0d.pc", i), pcfromras, exp_pc);
            chk($sformatf("drain%0d.count", i), 32'(count), 32'(i));
        end

        // Compare randomized traffic against the queue model.
        drive(0, 0, 0, 0, 32'h0);
        model_step(0, 0, 0, 0, 32'h0);
        phase_bias = 70;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic rn, fl, pu, po;
            logic [31:0] d;
            if (cyc % 100 == 0) phase_bias = (phase_bias == 70) ? 30 : 70;
            rn = ($urandom_range(0, 199) != 0);
            fl = ($urandom_range(0, 99) == 0);
            pu = ($urandom_range(0, 99) < phase_bias);
            po = ($urandom_range(0, 99) < (100 - phase_bias));
            d  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(rn, fl, pu, po, d);
            model_step(rn, fl, pu, po, d);
            exp_pc = (q.size() == 0) ? INV : q[q.size()-1];
            check_all($sformatf("rnd%0d", cyc), exp_pc, q.size(), q.size() == 0,
                      q.size() == DEPTH, m_ovf, m_unf);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_return_addr_stack
